// File: rtl/bitmap_text_renderer_pkg.sv
// Shared definitions for the banner renderer: screen geometry, scale
// encodings, image indices, blink FSM states and the scale-to-shift helper.
package bitmap_text_renderer_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned DEF_PIX_W = 10;

  // Image indices inside the banner ROM
  localparam int unsigned IMG_TURN = 0;
  localparam int unsigned IMG_WIN  = 1;
  localparam int unsigned IMG_LOSE = 2;

  typedef enum logic [1:0] {
    SCALE_1X     = 2'd0,
    SCALE_2X     = 2'd1,
    SCALE_4X     = 2'd2,
    SCALE_4X_ALT = 2'd3
  } scale_e;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_state_e;

  // Map the scale code to a left/right shift amount; code 3 aliases 4x
  function automatic logic [1:0] scale_shift(input logic [1:0] scale);
    logic [1:0] sh;
    case (scale)
      SCALE_1X: sh = 2'd0;
      SCALE_2X: sh = 2'd1;
      default:  sh = 2'd2;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/bitmap_blink_ctrl.sv
// Frame-counting blink controller for the banner renderer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   frame_tick  - one-cycle pulse per frame; advances the frame counter
//   blink_en    - blink enable; while low the banner is always visible
//   vis_c       - banner visibility (combinational from state and blink_en)
module bitmap_blink_ctrl
  import bitmap_text_renderer_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic blink_en,
  output logic vis_c
);

  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [FCNT_W-1:0] fcnt;
  blink_state_e      state;

  // Disabling blink parks the counter so re-enabling starts a full ON half-period
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      fcnt  <= '0;
      state <= BLINK_ON;
    end else if (frame_tick) begin
      if (fcnt == FCNT_LAST) begin
        fcnt  <= '0;
        state <= (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  assign vis_c = (state == BLINK_ON) | ~blink_en;

endmodule

// File: rtl/bitmap_text_renderer.sv
// Monochrome bitmap banner renderer with frame-synchronous attributes,
// integer scaling (1x/2x/4x) and blinking. Two-cycle latency from
// pixel_x/pixel_y to pixel_on/in_region; rom_addr is combinational and the
// external ROM returns data one cycle later.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   video_on            - visible-area flag from the sync generator
//   pixel_x, pixel_y    - current beam position
//   frame_tick          - start-of-vblank pulse; latches the attribute inputs
//   origin_x, origin_y  - requested banner top-left corner
//   img_sel, scale      - requested image index and scale code
//   show, blink_en      - banner enable, blink enable
//   rom_addr, rom_data  - banner ROM interface (row per address, MSB leftmost)
//   pixel_on, in_region - registered banner pixel and rectangle flag
module bitmap_text_renderer
  import bitmap_text_renderer_pkg::*;
#(
  parameter int unsigned IMG_W        = 80,
  parameter int unsigned IMG_H        = 44,
  parameter int unsigned NUM_IMG      = 4,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned PIX_W        = DEF_PIX_W,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on,
  input  logic [PIX_W-1:0]  pixel_x,
  input  logic [PIX_W-1:0]  pixel_y,
  input  logic              frame_tick,
  input  logic [PIX_W-1:0]  origin_x,
  input  logic [PIX_W-1:0]  origin_y,
  input  logic [1:0]        img_sel,
  input  logic [1:0]        scale,
  input  logic              show,
  input  logic              blink_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IMG_W-1:0]  rom_data,
  output logic              pixel_on,
  output logic              in_region
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  // Two extra bits so the 4x limits never overflow
  localparam int unsigned LIM_W = PIX_W + 2;

  logic [PIX_W-1:0] org_x_s;
  logic [PIX_W-1:0] org_y_s;
  logic [1:0]       img_s;
  logic [1:0]       scale_s;
  logic             show_s;

  logic [1:0]       sh;
  logic [PIX_W-1:0] rel_x;
  logic [PIX_W-1:0] rel_y;
  logic [LIM_W-1:0] lim_x;
  logic [LIM_W-1:0] lim_y;
  logic             img_ok;
  logic             hit_c;
  logic [PIX_W-1:0] row;
  logic [PIX_W-1:0] col;

  logic             hit_d;
  logic [COL_W-1:0] col_d;
  logic [COL_W-1:0] bit_idx;
  logic             vis;

  // Attribute shadows: only updated on frame_tick to avoid mid-frame tearing
  always_ff @(posedge clk) begin
    if (reset) begin
      org_x_s <= '0;
      org_y_s <= '0;
      img_s   <= '0;
      scale_s <= '0;
      show_s  <= 1'b0;
    end else if (frame_tick) begin
      org_x_s <= origin_x;
      org_y_s <= origin_y;
      img_s   <= img_sel;
      scale_s <= scale;
      show_s  <= show;
    end
  end

  // Stage 0: hit test and ROM row address. Pixels left/above the origin
  // wrap to large unsigned offsets and fail the bounds check.
  always_comb begin
    rom_addr = '0;
    sh       = scale_shift(scale_s);
    rel_x    = pixel_x - org_x_s;
    rel_y    = pixel_y - org_y_s;
    lim_x    = LIM_W'(IMG_W) << sh;
    lim_y    = LIM_W'(IMG_H) << sh;
    img_ok   = 32'(img_s) < NUM_IMG;
    hit_c    = video_on & show_s & img_ok &
               (LIM_W'(rel_x) < lim_x) & (LIM_W'(rel_y) < lim_y);
    row      = rel_y >> sh;
    col      = rel_x >> sh;
    if (hit_c) begin
      rom_addr = ADDR_W'(img_s) * ADDR_W'(IMG_H) + ADDR_W'(row);
    end
  end

  // Stage 1: carry hit and column alongside the ROM access
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_d <= 1'b0;
      col_d <= '0;
    end else begin
      hit_d <= hit_c;
      col_d <= hit_c ? COL_W'(col) : '0;
    end
  end

  // col_d is zero whenever hit_d is low, so the index always stays in range
  assign bit_idx = COL_W'(IMG_W - 1) - col_d;

  // Stage 2: select the pixel from the ROM row
  always_ff @(posedge clk) begin
    if (reset) begin
      in_region <= 1'b0;
      pixel_on  <= 1'b0;
    end else begin
      in_region <= hit_d;
      pixel_on  <= hit_d & vis & rom_data[bit_idx];
    end
  end

  bitmap_blink_ctrl #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .blink_en  (blink_en),
    .vis_c     (vis)
  );

endmodule
